// File: rtl/apb_timer_gen2_if.sv
// APB bus bundle for the gen2 timer: requester drives select/control/write data,
// the timer returns read data, ready and error.
interface apb_timer_gen2_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_timer_gen2.sv
// APB-programmable up/down timer with reload, one-shot, compare match and
// synchronised external tick selection.
module apb_timer_gen2 #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESET_n,
  apb_timer_gen2_if.slave       apb,
  input  logic [3:0]            Clk_in,
  output logic                  TMR_OVF,
  output logic                  TMR_UDF,
  output logic                  TMR_CMP
);
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned WW = 4;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e        state_q, state_c, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          ready_c, complete_c, err_c, wr_c;
  logic          wr_tdr_c, wr_tcr_c, wr_tsr_c, wr_tcmp_c;

  logic [DW-1:0] tdr_q, tcnt_q, tcmp_q, tcnt_d;
  logic          tcr_load_q, tcr_arld_q, tcr_down_q, tcr_en_q, tcr_os_q;
  logic [1:0]    tcr_cks_q;
  logic [2:0]    tsr_q, tsr_d;
  logic          load_pend_q;
  logic [2:0]    sync_q;
  logic          tick_c, cnt_upd_c, ovf_set_c, udf_set_c, cmp_set_c;
  logic [DW-1:0] tcr_rd_c;

  // A setup cycle on the bus is recognised in the same cycle so the access
  // phase lines up with the FSM's ACCESS state.
  always_comb begin
    state_c = state_q;
    state_d = state_q;
    wait_d  = wait_q;
    if (apb.PSEL && !apb.PENABLE) state_c = SETUP;
    case (state_c)
      IDLE:  state_d = IDLE;
      SETUP: begin
        state_d = ACCESS;
        wait_d  = WW'(WAIT_STATES);
      end
      ACCESS: begin
        if (!apb.PSEL)            state_d = IDLE;
        else if (wait_q != '0)    wait_d  = wait_q - WW'(1);
        else if (apb.PENABLE)     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign ready_c    = (state_c == ACCESS) && (wait_q == '0);
  assign complete_c = apb.PSEL && apb.PENABLE && ready_c;
  assign err_c      = complete_c && ((apb.PADDR > AW'(4)) ||
                                     (apb.PWRITE && apb.PADDR == AW'(3)));
  assign wr_c       = complete_c && apb.PWRITE && !err_c;
  assign wr_tdr_c   = wr_c && (apb.PADDR == AW'(0));
  assign wr_tcr_c   = wr_c && (apb.PADDR == AW'(1));
  assign wr_tsr_c   = wr_c && (apb.PADDR == AW'(2));
  assign wr_tcmp_c  = wr_c && (apb.PADDR == AW'(4));

  assign apb.PREADY  = ready_c;
  assign apb.PSLVERR = err_c;
  assign tcr_rd_c    = DW'({tcr_load_q, tcr_arld_q, tcr_down_q, tcr_en_q,
                            tcr_os_q, 1'b0, tcr_cks_q});

  always_comb begin
    apb.PRDATA = '0;
    if (complete_c && !err_c) begin
      case (apb.PADDR)
        AW'(0):  apb.PRDATA = tdr_q;
        AW'(1):  apb.PRDATA = tcr_rd_c;
        AW'(2):  apb.PRDATA = DW'(tsr_q);
        AW'(3):  apb.PRDATA = tcnt_q;
        AW'(4):  apb.PRDATA = tcmp_q;
        default: apb.PRDATA = '0;
      endcase
    end
  end

  assign tick_c = sync_q[1] && !sync_q[2];

  // A pending load pre-empts any tick; wrap values depend on ARLD.
  always_comb begin
    tcnt_d    = tcnt_q;
    cnt_upd_c = 1'b0;
    ovf_set_c = 1'b0;
    udf_set_c = 1'b0;
    if (load_pend_q) begin
      tcnt_d    = tdr_q;
      cnt_upd_c = 1'b1;
    end else if (tick_c && tcr_en_q) begin
      cnt_upd_c = 1'b1;
      if (!tcr_down_q) begin
        if (tcnt_q == '1) begin
          ovf_set_c = 1'b1;
          tcnt_d    = tcr_arld_q ? tdr_q : '0;
        end else begin
          tcnt_d = tcnt_q + DW'(1);
        end
      end else begin
        if (tcnt_q == '0) begin
          udf_set_c = 1'b1;
          tcnt_d    = tcr_arld_q ? tdr_q : '1;
        end else begin
          tcnt_d = tcnt_q - DW'(1);
        end
      end
    end
    cmp_set_c = cnt_upd_c && (tcnt_d == tcmp_q);
    tsr_d     = (tsr_q & ~(wr_tsr_c ? apb.PWDATA[2:0] : 3'b000)) |
                {cmp_set_c, udf_set_c, ovf_set_c};
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      tdr_q       <= '0;
      tcnt_q      <= '0;
      tcmp_q      <= '0;
      tcr_load_q  <= 1'b0;
      tcr_arld_q  <= 1'b0;
      tcr_down_q  <= 1'b0;
      tcr_en_q    <= 1'b0;
      tcr_os_q    <= 1'b0;
      tcr_cks_q   <= 2'b00;
      tsr_q       <= 3'b000;
      load_pend_q <= 1'b0;
      sync_q      <= 3'b000;
    end else begin
      sync_q      <= {sync_q[1:0], Clk_in[tcr_cks_q]};
      tcnt_q      <= tcnt_d;
      tsr_q       <= tsr_d;
      load_pend_q <= wr_tcr_c && apb.PWDATA[7] && !tcr_load_q;
      if (wr_tdr_c)  tdr_q  <= apb.PWDATA;
      if (wr_tcmp_c) tcmp_q <= apb.PWDATA;
      if (wr_tcr_c) begin
        tcr_load_q <= apb.PWDATA[7];
        tcr_arld_q <= apb.PWDATA[6];
        tcr_down_q <= apb.PWDATA[5];
        tcr_en_q   <= apb.PWDATA[4];
        tcr_os_q   <= apb.PWDATA[3];
        tcr_cks_q  <= apb.PWDATA[1:0];
      end
      if ((ovf_set_c || udf_set_c) && tcr_os_q) tcr_en_q <= 1'b0;
    end
  end

  assign TMR_OVF = tsr_q[0];
  assign TMR_UDF = tsr_q[1];
  assign TMR_CMP = tsr_q[2];
endmodule

// File: doc/apb_timer_gen2.md
Name: apb_timer_gen2

Overview:
- Second-generation APB-programmable timer. Replaces the fixed 8-bit timer.
- Adds the following over the first generation:
  - parametrised data width
  - configurable APB wait states
  - compare-match flag
  - auto-reload mode
  - one-shot mode
  - synchronised tick inputs
- Sits on the peripheral APB bus. TMR_OVF, TMR_UDF and TMR_CMP feed the interrupt controller.

Parameters:
- ADDR_WIDTH, 8: APB address width.
- DATA_WIDTH, 8: APB data width and counter width; must be >= 8.
- WAIT_STATES, 0: number of PREADY-low cycles inserted in each access phase; range 0..15.

Ports:
- PCLK  input  1  system clock; all logic is on the rising edge.
- PRESET_n  input  1  asynchronous active-low reset.
- PSEL  input  1  APB select.
- PENABLE  input  1  APB enable.
- PWRITE  input  1  APB direction; 1 = write.
- PADDR  input  ADDR_WIDTH  APB address.
- PWDATA  input  DATA_WIDTH  APB write data.
- PRDATA  output  DATA_WIDTH  APB read data.
- PREADY  output  1  APB ready.
- PSLVERR  output  1  APB error.
- Clk_in  input  4  external tick sources, asynchronous to PCLK.
- TMR_OVF  output  1  overflow flag (TSR[0]).
- TMR_UDF  output  1  underflow flag (TSR[1]).
- TMR_CMP  output  1  compare flag (TSR[2]).

Behaviour:
- Reset: one clock, PCLK. Reset is asynchronous and active-low on PRESET_n. All registers, the synchroniser and the FSM clear to 0. PRDATA, PREADY, PSLVERR and all TMR_* outputs are 0 during and after reset.
- Register map:
  - 0x00 TDR: read/write, reload value.
  - 0x01 TCR: read/write.
  - 0x02 TSR: write-1-to-clear.
  - 0x03 TCNT: read-only.
  - 0x04 TCMP: read/write.
- TCR bit fields:
  - [7] LOAD
  - [6] ARLD
  - [5] DOWN
  - [4] EN
  - [3] OS
  - [2] reserved; reads 0
  - [1:0] CKS
  - bits above 7 reserved; read 0
- APB FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP on PSEL & !PENABLE.
  - SETUP -> ACCESS on the next cycle; the wait counter loads WAIT_STATES.
  - In ACCESS, PREADY=0 while the counter is nonzero, decrementing each cycle. PREADY=1 when the counter is 0.
  - Completion cycle is PSEL & PENABLE & PREADY. The FSM returns to IDLE, or to SETUP if PSEL stays high with PENABLE low.
  - With WAIT_STATES=0, PREADY=1 in the first access cycle.
  - Dropping PSEL mid-access returns the FSM to IDLE with no side effect.
- Write commit: only on the completion cycle. Registers update at that PCLK edge.
- Read data: PRDATA is driven combinationally from the addressed register while PSEL & PENABLE & PREADY, and is 0 otherwise. Read data is TCNT's value at that cycle.
- PSLVERR:
  - Asserted only on the completion cycle.
  - Conditions: address > 0x04, or a write to TCNT.
  - Such writes have no effect. Such reads return 0.
- Tick path:
  - Clk_in[CKS] passes through a 2-flop synchroniser, then a rising-edge detector.
  - One-cycle tick pulse on the 3rd PCLK edge after the first edge that samples the input high.
  - Changing CKS can produce at most one spurious tick.
- LOAD:
  - A write that changes TCR.LOAD from 0 to 1 copies TDR into TCNT on the following cycle.
  - LOAD has priority over any tick in that cycle.
  - LOAD stays set until software clears it; it is not self-clearing.
- Counting: on a tick with EN=1 and no load, TCNT increments (DOWN=0) or decrements (DOWN=1), modulo 2^DATA_WIDTH.
- Overflow (up, TCNT = all-ones at the tick):
  - Next value is TDR if ARLD=1, else 0.
  - OVF is set.
- Underflow (down, TCNT = 0 at the tick):
  - Next value is TDR if ARLD=1, else all-ones.
  - UDF is set.
- One-shot: if OS=1, the same edge that sets OVF or UDF clears TCR.EN. The counter holds at the new value.
- Compare: CMP is set on the edge where TCNT is updated (tick or load) to a value equal to TCMP. A static equality does not re-set CMP.
- TSR clearing:
  - Writing 1 to a bit clears it.
  - A hardware set in the same cycle as a clear wins.
  - Writing 0 has no effect.
  - TSR bits above [2] read 0.
- Simultaneous APB write and tick:
  - A TCR write with EN=0 takes effect from the next cycle; the concurrent tick still counts under the old EN.
  - A TDR write in the same cycle as a reload uses the old TDR.
- Reset mid-transfer: the FSM returns to IDLE immediately and the pending write is discarded.

Test Plan:
- Reset, then read all five addresses -> every value 0x00, PSLVERR=0. With WAIT_STATES=2, PREADY is low for exactly 2 access cycles on each transfer.
- TDR=0xFF, TCR=0x80 then 0x00, TCR=0x10, two Clk_in[0] pulses -> TCNT=0x00 after the 1st pulse and TMR_OVF=1, TCNT=0x01 after the 2nd. Write TSR=0x01 -> TMR_OVF=0.
- TDR=0x05, load, TCR=0x70 (down, ARLD, EN), six ticks -> TCNT goes 4,3,2,1,0 then reloads to 0x05 and TMR_UDF=1.
- TDR=0xFE, load, TCR=0x18 (up, OS, EN), three ticks -> TCNT=0xFF, then 0x00 with OVF=1 and TCR reads 0x08 (EN cleared), then still 0x00 after the 3rd tick.
- TCMP=0x03, count up from 0 on Clk_in[2] (CKS=2) -> TMR_CMP rises on the edge TCNT becomes 3. A W1C of TSR in the same cycle as the match -> CMP remains 1.
- Write to 0x5A and to TCNT -> PSLVERR=1 on the completion cycle and no register changes. Assert PRESET_n low during the access phase of a TDR write -> TDR stays 0x00.
